// File: rtl/hazard_ctrl_if.sv
// Pipeline hazard control bundle: datapath stage info in, stall/flush/forward controls out.
// StallCycles/FlushCount exist only when HAZARD_PERF_EN is defined.
interface hazard_ctrl_if;
  logic [4:0] Rs1D;
  logic [4:0] Rs2D;
  logic [4:0] Rs1E;
  logic [4:0] Rs2E;
  logic [4:0] RdE;
  logic [1:0] ResultSrcE;
  logic       PCTakenE;
  logic [4:0] RdM;
  logic       RegWriteM;
  logic [4:0] RdW;
  logic       RegWriteW;
  logic       MemReqM;
  logic       MemReadyM;
  logic       StallF;
  logic       StallD;
  logic       StallE;
  logic       StallM;
  logic       FlushD;
  logic       FlushE;
  logic       FlushW;
  logic [1:0] ForwardAE;
  logic [1:0] ForwardBE;
  logic       MemTimeout;
`ifdef HAZARD_PERF_EN
  logic [31:0] StallCycles;
  logic [31:0] FlushCount;
`endif

`ifdef HAZARD_PERF_EN
  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, ResultSrcE, PCTakenE,
           RdM, RegWriteM, RdW, RegWriteW, MemReqM, MemReadyM,
    input  StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
           ForwardAE, ForwardBE, MemTimeout, StallCycles, FlushCount
  );
  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, ResultSrcE, PCTakenE,
           RdM, RegWriteM, RdW, RegWriteW, MemReqM, MemReadyM,
    output StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
           ForwardAE, ForwardBE, MemTimeout, StallCycles, FlushCount
  );
`else
  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, ResultSrcE, PCTakenE,
           RdM, RegWriteM, RdW, RegWriteW, MemReqM, MemReadyM,
    input  StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
           ForwardAE, ForwardBE, MemTimeout
  );
  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, ResultSrcE, PCTakenE,
           RdM, RegWriteM, RdW, RegWriteW, MemReqM, MemReadyM,
    output StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
           ForwardAE, ForwardBE, MemTimeout
  );
`endif
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage RV32I core: forwarding, load-use, branch flush, memory wait FSM.
// Optional perf counters (StallCycles, FlushCount) enabled by defining HAZARD_PERF_EN.
module hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input logic          clk,
  input logic          rst,
  hazard_ctrl_if.slave hz
);

  localparam int unsigned CNT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MEM_TIMEOUT);

  typedef enum logic {ST_RUN = 1'b0, ST_WAIT = 1'b1} state_t;

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;
  logic             mem_timeout;

  logic memstall;
  logic load_use;
  logic stall_f, stall_d, stall_e, stall_m;
  logic flush_d, flush_e, flush_w;
  logic [1:0] fwd_a, fwd_b;

  // Operand source for E; M wins over W, x0 never forwards.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                         input logic       wr_m, input logic [4:0] rd_m,
                                         input logic       wr_w, input logic [4:0] rd_w);
    logic [1:0] sel;
    sel = 2'b00;
    if (wr_m && (rd_m != 5'd0) && (rd_m == rs))      sel = 2'b10;
    else if (wr_w && (rd_w != 5'd0) && (rd_w == rs)) sel = 2'b01;
    return sel;
  endfunction

  assign memstall = hz.MemReqM && !hz.MemReadyM;
  assign load_use = (hz.ResultSrcE == 2'b01) && (hz.RdE != 5'd0) &&
                    ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D));

  // Priority: memory wait, then branch flush, then load-use.
  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    stall_m = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    flush_w = 1'b0;
    if (memstall) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      stall_e = 1'b1;
      stall_m = 1'b1;
      flush_w = 1'b1;
    end else if (hz.PCTakenE) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
    end else if (load_use) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      flush_e = 1'b1;
    end
  end

  always_comb begin
    fwd_a = fwd_sel(hz.Rs1E, hz.RegWriteM, hz.RdM, hz.RegWriteW, hz.RdW);
    fwd_b = fwd_sel(hz.Rs2E, hz.RegWriteM, hz.RdM, hz.RegWriteW, hz.RdW);
  end

  assign hz.StallF     = stall_f;
  assign hz.StallD     = stall_d;
  assign hz.StallE     = stall_e;
  assign hz.StallM     = stall_m;
  assign hz.FlushD     = flush_d;
  assign hz.FlushE     = flush_e;
  assign hz.FlushW     = flush_w;
  assign hz.ForwardAE  = fwd_a;
  assign hz.ForwardBE  = fwd_b;
  assign hz.MemTimeout = mem_timeout;

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cycles;
  logic [31:0] flush_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      stall_cycles <= stall_cycles + 32'(stall_f);
      flush_count  <= flush_count + 32'(flush_e);
    end
  end

  assign hz.StallCycles = stall_cycles;
  assign hz.FlushCount  = flush_count;
`endif

  // Wait-state FSM; the watchdog only reports, it never releases the stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_RUN;
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          wait_cnt <= '0;
          if (memstall) state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (wait_cnt != CNT_MAX) wait_cnt <= wait_cnt + CNT_W'(1);
          if (wait_cnt == CNT_MAX) mem_timeout <= 1'b1;
          if (!memstall) state <= ST_RUN;
        end
        default: begin
          state    <= ST_RUN;
          wait_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl (MEM_TIMEOUT=4): directed scenarios plus randomized traffic vs a rule-level model.
// Perf counter checks are compiled in when HAZARD_PERF_EN is defined.
module tb_hazard_ctrl;

  localparam int unsigned T = 4;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  hazard_ctrl_if hz();

  hazard_ctrl #(.MEM_TIMEOUT(T)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state: consecutive memory-wait cycles so far, sticky timeout, perf tallies.
  int          m_run;
  bit          m_to;
  logic [31:0] m_stall;
  logic [31:0] m_flush;

  // Expected combinational outputs: {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushW}
  bit         e_ms;
  logic [6:0] e_ctl;
  logic [1:0] e_fa;
  logic [1:0] e_fb;

  function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
    if (hz.RegWriteM && hz.RdM != 0 && hz.RdM == rs) return 2'b10;
    if (hz.RegWriteW && hz.RdW != 0 && hz.RdW == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [6:0] act_ctl();
    return {hz.StallF, hz.StallD, hz.StallE, hz.StallM, hz.FlushD, hz.FlushE, hz.FlushW};
  endfunction

  task automatic calc();
    bit br, lu;
    e_ms  = hz.MemReqM && !hz.MemReadyM;
    br    = !e_ms && hz.PCTakenE;
    lu    = !e_ms && !hz.PCTakenE && hz.ResultSrcE == 2'b01 && hz.RdE != 0 &&
            (hz.RdE == hz.Rs1D || hz.RdE == hz.Rs2D);
    e_ctl = {e_ms | lu, e_ms | lu, e_ms, e_ms, br, br | lu, e_ms};
    e_fa  = ref_fwd(hz.Rs1E);
    e_fb  = ref_fwd(hz.Rs2E);
  endtask

  // Advance one clock, updating the model with this cycle's inputs.
  task automatic tick();
    calc();
    if (!rst) begin
      if (m_run >= int'(T) + 1) m_to = 1'b1;
      m_run   = e_ms ? m_run + 1 : 0;
      m_stall = m_stall + 32'(e_ctl[6]);
      m_flush = m_flush + 32'(e_ctl[1]);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    hz.Rs1D = 0; hz.Rs2D = 0; hz.Rs1E = 0; hz.Rs2E = 0; hz.RdE = 0;
    hz.ResultSrcE = 0; hz.PCTakenE = 0; hz.RdM = 0; hz.RegWriteM = 0;
    hz.RdW = 0; hz.RegWriteW = 0; hz.MemReqM = 0; hz.MemReadyM = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    m_run = 0; m_to = 1'b0; m_stall = '0; m_flush = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    m_run = 0; m_to = 1'b0; m_stall = '0; m_flush = '0;
    @(negedge clk);
    checks++;
    if (act_ctl() !== 7'b0) begin
      errors++; $display("FAIL reset_ctl: got=%b expected=%b", act_ctl(), 7'b0);
    end
    checks++;
    if ({hz.ForwardAE, hz.ForwardBE, hz.MemTimeout} !== 5'b0) begin
      errors++; $display("FAIL reset_fwd_to: got=%b expected=%b", {hz.ForwardAE, hz.ForwardBE, hz.MemTimeout}, 5'b0);
    end
`ifdef HAZARD_PERF_EN
    checks++;
    if (hz.StallCycles !== 32'd0 || hz.FlushCount !== 32'd0) begin
      errors++; $display("FAIL reset_perf: got=%0d/%0d expected=0/0", hz.StallCycles, hz.FlushCount);
    end
`endif
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_forwarding();
    idle_inputs();
    hz.Rs1E = 5; hz.RdM = 5; hz.RegWriteM = 1; hz.RdW = 5; hz.RegWriteW = 1; hz.Rs2E = 9;
    @(negedge clk);
    checks++;
    if (hz.ForwardAE !== 2'b10) begin
      errors++; $display("FAIL fwd_m_prio: got=%b expected=%b", hz.ForwardAE, 2'b10);
    end
    checks++;
    if (hz.ForwardBE !== 2'b00) begin
      errors++; $display("FAIL fwd_b_none: got=%b expected=%b", hz.ForwardBE, 2'b00);
    end
    tick();
    hz.RegWriteM = 0; hz.Rs2E = 5;
    @(negedge clk);
    checks++;
    if (hz.ForwardAE !== 2'b01 || hz.ForwardBE !== 2'b01) begin
      errors++; $display("FAIL fwd_w: got=%b/%b expected=01/01", hz.ForwardAE, hz.ForwardBE);
    end
    tick();
    hz.RegWriteM = 1; hz.RdM = 0; hz.RdW = 0; hz.Rs1E = 0; hz.Rs2E = 0;
    @(negedge clk);
    checks++;
    if (hz.ForwardAE !== 2'b00 || hz.ForwardBE !== 2'b00) begin
      errors++; $display("FAIL fwd_x0: got=%b/%b expected=00/00", hz.ForwardAE, hz.ForwardBE);
    end
    tick();
  endtask

  task automatic test_load_use();
    idle_inputs();
    hz.ResultSrcE = 2'b01; hz.RdE = 7; hz.Rs2D = 7;
    @(negedge clk);
    checks++;
    if (act_ctl() !== 7'b1100010) begin
      errors++; $display("FAIL load_use: got=%b expected=%b", act_ctl(), 7'b1100010);
    end
    tick();
    idle_inputs();
    @(negedge clk);
    checks++;
    if (act_ctl() !== 7'b0) begin
      errors++; $display("FAIL load_use_release: got=%b expected=%b", act_ctl(), 7'b0);
    end
    tick();
    hz.ResultSrcE = 2'b01; hz.RdE = 0; hz.Rs2D = 0; hz.Rs1D = 0;
    @(negedge clk);
    checks++;
    if (act_ctl() !== 7'b0) begin
      errors++; $display("FAIL load_use_x0: got=%b expected=%b", act_ctl(), 7'b0);
    end
    tick();
  endtask

  task automatic test_branch_load_use();
    idle_inputs();
    hz.PCTakenE = 1; hz.ResultSrcE = 2'b01; hz.RdE = 3; hz.Rs1D = 3;
    @(negedge clk);
    checks++;
    if (act_ctl() !== 7'b0000110) begin
      errors++; $display("FAIL branch_over_lu: got=%b expected=%b", act_ctl(), 7'b0000110);
    end
    tick();
  endtask

  task automatic test_mem_branch();
    idle_inputs();
    hz.MemReqM = 1; hz.MemReadyM = 0; hz.PCTakenE = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (act_ctl() !== 7'b1111001) begin
        errors++; $display("FAIL mem_wait_branch[%0d]: got=%b expected=%b", i, act_ctl(), 7'b1111001);
      end
      tick();
    end
    hz.MemReadyM = 1;
    @(negedge clk);
    checks++;
    if (act_ctl() !== 7'b0000110) begin
      errors++; $display("FAIL mem_ready_branch: got=%b expected=%b", act_ctl(), 7'b0000110);
    end
    checks++;
    if (hz.MemTimeout !== 1'b0) begin
      errors++; $display("FAIL mem_short_no_to: got=%b expected=0", hz.MemTimeout);
    end
    tick();
    idle_inputs();
    tick();
  endtask

  task automatic test_perf();
    do_reset();
    hz.ResultSrcE = 2'b01; hz.RdE = 9; hz.Rs1D = 9;
    repeat (2) tick();
    idle_inputs();
    hz.PCTakenE = 1;
    repeat (3) tick();
    idle_inputs();
    tick();
    @(negedge clk);
`ifdef HAZARD_PERF_EN
    checks++;
    if (hz.StallCycles !== 32'd2) begin
      errors++; $display("FAIL perf_stall: got=%0d expected=2", hz.StallCycles);
    end
    checks++;
    if (hz.FlushCount !== 32'd5) begin
      errors++; $display("FAIL perf_flush: got=%0d expected=5", hz.FlushCount);
    end
`endif
    checks++;
    if (act_ctl() !== 7'b0) begin
      errors++; $display("FAIL perf_idle: got=%b expected=%b", act_ctl(), 7'b0);
    end
    tick();
  endtask

  task automatic test_watchdog();
    idle_inputs();
    hz.MemReqM = 1; hz.MemReadyM = 0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      checks++;
      if (hz.MemTimeout !== 1'b0 || m_to !== 1'b0) begin
        errors++; $display("FAIL wd_early[%0d]: got=%b model=%b expected=0", k, hz.MemTimeout, m_to);
      end
      tick();
    end
    hz.MemReqM = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (hz.MemTimeout !== 1'b1) begin
        errors++; $display("FAIL wd_sticky[%0d]: got=%b expected=1", k, hz.MemTimeout);
      end
      tick();
    end
    hz.MemReqM = 1;
    repeat (2) tick();
    rst = 1'b1;
    m_run = 0; m_to = 1'b0; m_stall = '0; m_flush = '0;
    @(negedge clk);
    checks++;
    if (hz.MemTimeout !== 1'b0) begin
      errors++; $display("FAIL wd_reset_clear: got=%b expected=0", hz.MemTimeout);
    end
    checks++;
    if (act_ctl() !== 7'b1111001) begin
      errors++; $display("FAIL wd_reset_stall: got=%b expected=%b", act_ctl(), 7'b1111001);
    end
    tick();
    rst = 1'b0;
    // Timeout must need a full fresh wait after reset.
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      checks++;
      if (hz.MemTimeout !== m_to || hz.MemTimeout !== (k == 7)) begin
        errors++; $display("FAIL wd_after_reset[%0d]: got=%b model=%b", k, hz.MemTimeout, m_to);
      end
      tick();
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      hz.Rs1D = 5'($urandom_range(0, 3)); hz.Rs2D = 5'($urandom_range(0, 3));
      hz.Rs1E = 5'($urandom_range(0, 3)); hz.Rs2E = 5'($urandom_range(0, 3));
      hz.RdE  = 5'($urandom_range(0, 3)); hz.RdM  = 5'($urandom_range(0, 3));
      hz.RdW  = 5'($urandom_range(0, 3));
      hz.ResultSrcE = 2'($urandom_range(0, 3));
      hz.PCTakenE   = ($urandom_range(0, 3) == 0);
      hz.RegWriteM  = 1'($urandom);
      hz.RegWriteW  = 1'($urandom);
      hz.MemReqM    = ($urandom_range(0, 2) == 0);
      hz.MemReadyM  = 1'($urandom);
      @(negedge clk);
      calc();
      checks++;
      if (act_ctl() !== e_ctl) begin
        errors++; $display("FAIL rnd_ctl[%0d]: got=%b expected=%b", i, act_ctl(), e_ctl);
      end
      checks++;
      if (hz.ForwardAE !== e_fa || hz.ForwardBE !== e_fb) begin
        errors++; $display("FAIL rnd_fwd[%0d]: got=%b/%b expected=%b/%b", i, hz.ForwardAE, hz.ForwardBE, e_fa, e_fb);
      end
      checks++;
      if (hz.MemTimeout !== m_to) begin
        errors++; $display("FAIL rnd_timeout[%0d]: got=%b expected=%b", i, hz.MemTimeout, m_to);
      end
`ifdef HAZARD_PERF_EN
      checks++;
      if (hz.StallCycles !== m_stall || hz.FlushCount !== m_flush) begin
        errors++; $display("FAIL rnd_perf[%0d]: got=%0d/%0d expected=%0d/%0d", i, hz.StallCycles, hz.FlushCount, m_stall, m_flush);
      end
`endif
      tick();
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b0;
    idle_inputs();
    #2;
    test_reset();
    test_forwarding();
    test_load_use();
    test_branch_load_use();
    test_mem_branch();
    test_perf();
    test_watchdog();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
